// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Sequencer between a UART byte receiver and instruction/data memory.
//   Parses a framed download:
//     SYNC_BYTE, count[7:0], count[15:8], then count little-endian 32-bit words.
//   Each word is written over a req/ack handshake to consecutive word
//   addresses starting at BASE_ADDR.
//   The CPU is held in reset until the whole image has been written.
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   An 8-bit XOR of all data bytes is accumulated.
//   After the last word the next byte must match it, otherwise ERROR.
//
// Parameters:
//   ADDR_W     memory byte-address width
//   BASE_ADDR  byte address of the first word written
//   SYNC_BYTE  frame start marker
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid   received byte + single-cycle valid
//   i_restart               re-arms the loader from DONE or ERROR
//   o_mem_req, o_mem_addr,
//   o_mem_wdata, i_mem_ack  memory write handshake; request held until ack
//   o_cpu_rst_n             CPU reset (active-low), released once loaded
//   o_busy                  frame in progress
//   o_done                  image loaded
//   o_error                 sticky error (sync lost / overrun / bad checksum)

module uart_boot_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0]        SYNC_BYTE = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_restart,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef BOOT_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  // State entered once the last word has been written (or for an empty image).
`ifdef BOOT_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t            state, state_next;
  logic [15:0]       remaining;   // count low byte is parked here in LEN0
  logic [1:0]        byte_idx;
  logic [23:0]       word_lo;     // bytes 0..2 of the word being assembled
  logic              pend_valid;
  logic [7:0]        pend_data;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              done_q;

  logic              rx_in_write;
  logic              overrun;
  logic              write_ack;
  logic              last_word;
  logic              count_zero;
  logic              carry_valid;
  logic [7:0]        carry_byte;
  logic              in_chk;

  // A byte arriving during WRITE while one is already parked is an overrun;
  // the overrun takes priority over a simultaneous ack.
  assign rx_in_write = (state == S_WRITE) && i_rx_valid;
  assign overrun     = rx_in_write && pend_valid;
  assign write_ack   = (state == S_WRITE) && i_mem_ack && !overrun;
  assign last_word   = (remaining == 16'd1);
  assign count_zero  = (i_rx_data == 8'd0) && (remaining[7:0] == 8'd0);

  // Byte that becomes index 0 of the next word when a write completes:
  // the parked byte if any, else one arriving in the ack cycle itself.
  assign carry_valid = pend_valid || rx_in_write;
  assign carry_byte  = pend_valid ? pend_data : i_rx_data;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_byte_valid;
  logic [7:0] chk_byte;

  // A byte parked during the last write is the checksum byte.
  assign chk_byte_valid = pend_valid || i_rx_valid;
  assign chk_byte       = pend_valid ? pend_data : i_rx_data;
  assign in_chk         = (state == S_CHK);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chk_acc <= 8'd0;
    end else if ((state == S_LEN0) && i_rx_valid) begin
      chk_acc <= 8'd0;
    end else if ((state == S_DATA) && i_rx_valid) begin
      chk_acc <= chk_acc ^ i_rx_data;
    end else if (write_ack && !last_word && carry_valid) begin
      chk_acc <= chk_acc ^ carry_byte;
    end
  end
`else
  assign in_chk = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: clocked processes use non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment covers every path through the case, so
    // no latch is inferred for state_next.
    state_next = state;
    case (state)
      S_IDLE:  if (i_rx_valid && (i_rx_data == SYNC_BYTE)) state_next = S_LEN0;
      S_LEN0:  if (i_rx_valid) state_next = S_LEN1;
      S_LEN1:  if (i_rx_valid) state_next = count_zero ? S_FINAL : S_DATA;
      S_DATA:  if (i_rx_valid && (byte_idx == 2'd3)) state_next = S_WRITE;
      S_WRITE: begin
        if (overrun)        state_next = S_ERROR;
        else if (write_ack) state_next = last_word ? S_FINAL : S_DATA;
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK:   if (chk_byte_valid) state_next = (chk_byte == chk_acc) ? S_DONE : S_ERROR;
`endif
      S_DONE:  if (i_restart) state_next = S_IDLE;
      S_ERROR: if (i_restart) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: length, word assembly, address and pending byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      remaining  <= 16'd0;
      byte_idx   <= 2'd0;
      word_lo    <= 24'd0;
      pend_valid <= 1'b0;
      pend_data  <= 8'd0;
      addr       <= BASE_ADDR;
      wdata      <= 32'd0;
    end else begin
      case (state)
        S_IDLE: pend_valid <= 1'b0;
        S_LEN0: if (i_rx_valid) remaining[7:0] <= i_rx_data;
        S_LEN1: begin
          if (i_rx_valid) begin
            remaining[15:8] <= i_rx_data;
            addr            <= BASE_ADDR;
            byte_idx        <= 2'd0;
            pend_valid      <= 1'b0;
          end
        end
        S_DATA: begin
          if (i_rx_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    word_lo[7:0]   <= i_rx_data;
              2'd1:    word_lo[15:8]  <= i_rx_data;
              2'd2:    word_lo[23:16] <= i_rx_data;
              default: wdata          <= {i_rx_data, word_lo};
            endcase
          end
        end
        S_WRITE: begin
          if (write_ack) begin
            addr      <= addr + ADDR_W'(4);
            remaining <= remaining - 16'd1;
          end
          if (write_ack && !last_word) begin
            // Start the next word with the carried byte, if there is one.
            if (carry_valid) begin
              word_lo[7:0] <= carry_byte;
              byte_idx     <= 2'd1;
              pend_valid   <= 1'b0;
            end else begin
              byte_idx <= 2'd0;
            end
          end else if (rx_in_write && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_data  <= i_rx_data;
          end
        end
        default: pend_valid <= 1'b0;
      endcase
    end
  end

  // o_done / o_cpu_rst_n follow DONE by one cycle and drop with the restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_DONE) && !i_restart;
    end
  end

  // The request is a pure state decode, so an asynchronous reset drops it
  // at once.
  assign o_mem_req   = (state == S_WRITE);
  assign o_mem_addr  = addr;
  assign o_mem_wdata = wdata;
  assign o_done      = done_q;
  assign o_cpu_rst_n = done_q;
  assign o_error     = (state == S_ERROR);
  assign o_busy      = in_chk || (state inside {S_LEN0, S_LEN1, S_DATA, S_WRITE});

endmodule
